// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline-stage register with optional two-entry skid buffer,
// flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    StEmpty,
    StFull1,
    StFull2
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc, pop;

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and payload steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A beat accepted this cycle is dropped along with everything held.
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            state_d = StFull1;
            main_d  = in_data;
          end
        end
        StFull1: begin
          if (acc && pop) begin
            main_d = in_data;
          end else if (acc && (SKID != 0)) begin
            state_d = StFull2;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = StEmpty;
            main_d  = '0;
          end
        end
        StFull2: begin
          if (pop) begin
            state_d = StFull1;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Outputs: with the skid buffer, in_ready depends only on registered state.
  always_comb begin
    out_valid = (state_q != StEmpty);
    if (rst) begin
      in_ready = 1'b0;
    end else if (SKID != 0) begin
      in_ready = (state_q != StFull2);
    end else begin
      in_ready = (state_q == StEmpty) | out_ready;
    end
  end

  assign acc      = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = main_q;

  // Stall counter ignores flush and saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: skid, saturating-counter and
// no-skid instances driven from one linear sequence.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Instance 0: SKID=1, CNT_W=16
  logic        flush0, iv0, ir0, ov0, ordy0;
  logic [31:0] id0, od0;
  logic [15:0] sc0;
  // Instance 1: SKID=1, CNT_W=2
  logic        flush1, iv1, ir1, ov1, ordy1;
  logic [31:0] id1, od1;
  logic [1:0]  sc1;
  // Instance 2: SKID=0
  logic        flush2, iv2, ir2, ov2, ordy2;
  logic [31:0] id2, od2;
  logic [15:0] sc2;

  pipe_stage_skid #(.DATA_W(32), .SKID(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .stall_cnt(sc0)
  );

  pipe_stage_skid #(.DATA_W(32), .SKID(1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .stall_cnt(sc1)
  );

  pipe_stage_skid #(.DATA_W(32), .SKID(0), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .flush(flush2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .stall_cnt(sc2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush0 = 0; iv0 = 1; id0 = 32'hdead; ordy0 = 0;
    flush1 = 0; iv1 = 0; id1 = 0;        ordy1 = 0;
    flush2 = 0; iv2 = 0; id2 = 0;        ordy2 = 0;

    // Reset for two cycles with in_valid high
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_in_ready", {31'd0, ir0}, 32'd0);
      check("rst_out_valid", {31'd0, ov0}, 32'd0);
      check("rst_out_data", od0, 32'd0);
      check("rst_stall_cnt", {16'd0, sc0}, 32'd0);
    end
    rst = 1'b0; iv0 = 0;
    step();
    check("idle_in_ready", {31'd0, ir0}, 32'd1);
    check("idle_out_valid", {31'd0, ov0}, 32'd0);

    // Streaming 1..4 with out_ready high
    ordy0 = 1; iv0 = 1;
    for (int i = 1; i <= 4; i++) begin
      id0 = i;
      step();
      check("stream_out_data", od0, i);
      check("stream_out_valid", {31'd0, ov0}, 32'd1);
      check("stream_in_ready", {31'd0, ir0}, 32'd1);
    end
    iv0 = 0;
    step();
    check("stream_drain_valid", {31'd0, ov0}, 32'd0);
    check("stream_drain_data", od0, 32'd0);
    check("stream_stall_cnt", {16'd0, sc0}, 32'd0);

    // Back-pressure into FULL2
    ordy0 = 0; iv0 = 1; id0 = 32'h11;
    step();
    check("bp_a_data", od0, 32'h11);
    check("bp_a_in_ready", {31'd0, ir0}, 32'd1);
    check("bp_a_stall_cnt", {16'd0, sc0}, 32'd0);
    id0 = 32'h22;
    step();
    check("bp_full2_in_ready", {31'd0, ir0}, 32'd0);
    check("bp_full2_data", od0, 32'h11);
    check("bp_stall_cnt1", {16'd0, sc0}, 32'd1);
    id0 = 32'h99;  // must not be accepted while in_ready=0
    step();
    check("bp_hold_data", od0, 32'h11);
    check("bp_stall_cnt2", {16'd0, sc0}, 32'd2);
    step();
    check("bp_hold_in_ready", {31'd0, ir0}, 32'd0);
    check("bp_stall_cnt3", {16'd0, sc0}, 32'd3);
    iv0 = 0; ordy0 = 1;
    #1;
    check("bp_head_before_pop", od0, 32'h11);
    step();
    check("bp_second_data", od0, 32'h22);
    check("bp_second_valid", {31'd0, ov0}, 32'd1);
    check("bp_second_in_ready", {31'd0, ir0}, 32'd1);
    step();
    check("bp_empty_valid", {31'd0, ov0}, 32'd0);
    check("bp_empty_data", od0, 32'd0);
    check("bp_cnt_kept", {16'd0, sc0}, 32'd3);

    // Flush from FULL2 with a new beat offered
    ordy0 = 0; iv0 = 1; id0 = 32'h11;
    step();
    id0 = 32'h22;
    step();
    check("fl_full2_data", od0, 32'h11);
    check("fl_full2_stall", {16'd0, sc0}, 32'd4);
    flush0 = 1; id0 = 32'h33;
    step();
    check("fl_out_valid", {31'd0, ov0}, 32'd0);
    check("fl_out_data", od0, 32'd0);
    check("fl_in_ready", {31'd0, ir0}, 32'd1);
    check("fl_stall_not_cleared", {16'd0, sc0}, 32'd5);
    flush0 = 0; iv0 = 0;
    step();
    check("fl_no_0x33_valid", {31'd0, ov0}, 32'd0);
    check("fl_no_0x33_data", od0, 32'd0);

    // Flush while accepting and popping in FULL1 discards the new beat
    iv0 = 1; id0 = 32'h44;
    step();
    check("fl1_load", od0, 32'h44);
    flush0 = 1; ordy0 = 1; id0 = 32'h55;
    step();
    check("fl1_valid", {31'd0, ov0}, 32'd0);
    check("fl1_data", od0, 32'd0);
    flush0 = 0; iv0 = 0;
    step();
    check("fl1_stays_empty", {31'd0, ov0}, 32'd0);
    check("fl1_stall_cnt", {16'd0, sc0}, 32'd5);

    // Saturation with CNT_W=2
    iv1 = 1; id1 = 32'ha; ordy1 = 0;
    step();
    check("sat_loaded", od1, 32'ha);
    check("sat_cnt0", {30'd0, sc1}, 32'd0);
    iv1 = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("sat_cnt", {30'd0, sc1}, (i < 3) ? i : 3);
    end
    check("sat_data_held", od1, 32'ha);

    // SKID=0: combinational in_ready
    iv2 = 1; id2 = 32'h5; ordy2 = 0;
    step();
    check("ns_load", od2, 32'h5);
    check("ns_in_ready_stalled", {31'd0, ir2}, 32'd0);
    ordy2 = 1; id2 = 32'h6;
    #1;
    check("ns_in_ready_comb", {31'd0, ir2}, 32'd1);
    step();
    check("ns_acc_pop_data", od2, 32'h6);
    check("ns_acc_pop_valid", {31'd0, ov2}, 32'd1);
    iv2 = 0;
    step();
    check("ns_drain_valid", {31'd0, ov2}, 32'd0);
    check("ns_drain_data", od2, 32'd0);
    check("ns_stall_cnt", {16'd0, sc2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
